sbc32_seq: RTL and testbench
============================

// Module: sbc32_seq
// PURPOSE
//  Multi-cycle WIDTH-bit subtract-with-borrow unit: d = a - b - Bi (mod 2^WIDTH), with borrow-out and signed overflow.
//  Complement of the combinational ADC32 adder. Processes CHUNK bits per clock, trading latency for a short borrow chain.
//  Sits in the ALU datapath behind a valid/ready handshake and feeds results to the writeback stage.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK (elaboration-time check, $error otherwise)
//  CHUNK   8  bits subtracted per RUN cycle; STEPS = WIDTH/CHUNK (4 by default)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a, b, Bi valid
//  in_ready   out  1      unit can accept operands (IDLE only)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  Bi         in   1      borrow in
//  out_valid  out  1      d, Bo, V valid (DONE only)
//  out_ready  in   1      consumer takes result
//  d          out  WIDTH  difference
//  Bo         out  1      borrow out: 1 iff a < b + Bi (unsigned)
//  V          out  1      signed overflow: a[W-1]!=b[W-1] && d[W-1]!=a[W-1]
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, d=0, Bo=0, V=0, step=0, internal borrow=0. rst overrides all inputs.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid at an edge, latch a, b, Bi into operand regs and clear d. Set borrow=Bi, step=0, go RUN.
//   RUN: in_ready=0, out_valid=0. Each edge computes chunk[step] = a_c - b_c - borrow on CHUNK bits (CHUNK+1-bit arithmetic),
//        writes d[step*CHUNK +: CHUNK] and sets borrow = borrow-out of the chunk. After step STEPS-1, set Bo=borrow and V per formula, then go DONE.
//   DONE: out_valid=1; d, Bo, V held stable. Edge with out_ready=1 -> IDLE (out_valid drops next cycle). in_valid is ignored.
//  Latency: operands accepted at edge k -> out_valid high after edge k+STEPS. Min throughput is one op per STEPS+2 cycles.
//  in_valid during RUN/DONE: ignored, not queued. Producer must hold until in_ready.
//  Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
//  Reset mid-RUN or mid-DONE: operation aborted, state reset as above the following cycle, no output produced.
//  Arithmetic is modulo 2^WIDTH. Bo equals ~carry-out of a + ~b + ~Bi. d/Bo/V are only meaningful while out_valid=1.
//  d changes only in RUN; it is not cleared on leaving DONE.
// STRUCTURE
//  Shared package (alu_pkg): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//   default WIDTH/CHUNK constants. The STEPS derivation stays local to this block.
//  One sub-module, sbc_chunk #(CHUNK): combinational x - y - bin -> diff[CHUNK-1:0], bout. Instantiated once, muxed by step.
//  Top holds FSM, step counter ($clog2(STEPS) bits, min 1), operand regs, result reg, borrow flop.
// TESTING (default WIDTH=32, CHUNK=8)
//  AAAAAAAA - 55555555, Bi=0 -> out_valid 4 cycles after accept; d=55555555, Bo=0, V=1
//  00000100 - 00000001, Bi=0 -> d=000000FF, Bo=0, V=0 (borrow crosses chunk boundary)
//  00000000 - 00000001, Bi=0 -> d=FFFFFFFF, Bo=1, V=0; 80000000 - 00000001 -> d=7FFFFFFF, Bo=0, V=1
//  FFFFFFFF - FFFFFFFF, Bi=1 -> d=FFFFFFFF, Bo=1, V=0
//  out_ready low 5 cycles in DONE, in_valid pulsed meanwhile -> d/Bo/V stable, in_ready=0, pulse ignored; one result per accept
//  rst asserted at RUN step 2 -> next cycle IDLE, in_ready=1, out_valid=0, d=0; subsequent op 00000005-00000003 -> d=00000002

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU datapath constants, including the multi-cycle
//               unit state encoding and the default operand geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } seq_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sbc_chunk.sv
`default_nettype none
// ============================================================================
// Module      : sbc_chunk
// Description : Combinational CHUNK-bit subtract-with-borrow slice
//               (x - y - bin) producing the difference and borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module sbc_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] diff_o,
    output logic             bout_o
);

    logic [CHUNK:0] w_ext;

    // The extra top bit goes to 1 exactly when the result underflows.
    assign w_ext  = {1'b0, x_i} - {1'b0, y_i} - {{CHUNK{1'b0}}, bin_i};
    assign diff_o = w_ext[CHUNK-1:0];
    assign bout_o = w_ext[CHUNK];

endmodule : sbc_chunk
`default_nettype wire

// File: rtl/sbc32_seq.sv
`default_nettype none
// ============================================================================
// Module      : sbc32_seq
// Description : Multi-cycle subtract-with-borrow unit, CHUNK bits per cycle,
//               with valid/ready handshakes, borrow-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sbc32_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             Bo,
    output logic             V
);

    localparam int STEPS  = WIDTH / CHUNK;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(STEPS - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
            $error("sbc32_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    seq_state_e        state_q,  state_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [WIDTH-1:0]  a_q,      a_d;
    logic [WIDTH-1:0]  b_q,      b_d;
    logic [WIDTH-1:0]  d_q,      d_d;
    logic              borrow_q, borrow_d;
    logic              bo_q,     bo_d;
    logic              v_q,      v_d;

    logic [CHUNK-1:0]  w_x;
    logic [CHUNK-1:0]  w_y;
    logic [CHUNK-1:0]  w_diff;
    logic              w_bout;

    // One shared slice; the step counter selects which chunk it works on.
    assign w_x = a_q[int'(step_q) * CHUNK +: CHUNK];
    assign w_y = b_q[int'(step_q) * CHUNK +: CHUNK];

    sbc_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x_i    (w_x),
        .y_i    (w_y),
        .bin_i  (borrow_q),
        .diff_o (w_diff),
        .bout_o (w_bout)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        v_d      = v_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    d_d      = '0;
                    borrow_d = Bi;
                    step_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                d_d[int'(step_q) * CHUNK +: CHUNK] = w_diff;
                borrow_d = w_bout;
                if (step_q == C_LAST_STEP) begin
                    // The top chunk's MSB is the result sign bit.
                    bo_d    = w_bout;
                    v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (w_diff[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            v_q      <= v_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign d         = d_q;
    assign Bo        = bo_q;
    assign V         = v_q;

endmodule : sbc32_seq
`default_nettype wire

// File: tb/tb_sbc32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbc32_seq
// Description : Self-checking bench for sbc32_seq: directed corner cases,
//               backpressure, mid-run reset and random operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbc32_seq;

    localparam int W     = 32;
    localparam int STEPS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Bi;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         Bo;
    logic         V;

    int n_cmp = 0;
    int n_err = 0;

    sbc32_seq #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Bi        (Bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .Bo        (Bo),
        .V         (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the definition.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi,
                         output logic [W-1:0] md, output logic mbo, output logic mv);
        longint unsigned ua, ub, t;
        ua  = longint'(ma);
        ub  = longint'(mb) + longint'(mbi);
        t   = (ua + 64'h1_0000_0000 - ub);
        md  = t[W-1:0];
        mbo = (ua < ub);
        mv  = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    endtask

    // Issue one operation; hold_cyc > 0 stalls DONE and pulses in_valid meanwhile.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obi,
                          input int hold_cyc, input string tag);
        logic [W-1:0] ed;
        logic         ebo, ev;
        int           n;
        model(oa, ob, obi, ed, ebo, ev);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":ready_wait"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        Bi       = obi;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check({tag, ":busy"}, 64'(in_ready), 64'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(STEPS));
        check({tag, ":d"},  64'(d),  64'(ed));
        check({tag, ":Bo"}, 64'(Bo), 64'(ebo));
        check({tag, ":V"},  64'(V),  64'(ev));
        if (hold_cyc > 0) begin
            for (int i = 0; i < hold_cyc; i++) begin
                in_valid = (i == 1);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            check({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, ":hold_ready"}, 64'(in_ready), 64'(0));
            check({tag, ":hold_d"}, {31'b0, Bo, V, d}, {31'b0, ebo, ev, ed});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ":drop_valid"}, 64'(out_valid), 64'(0));
        check({tag, ":idle_ready"}, 64'(in_ready), 64'(1));
        check({tag, ":d_kept"}, 64'(d), 64'(ed));
        if (hold_cyc > 0) begin
            repeat (STEPS + 2) @(posedge clk);
            #1;
            check({tag, ":no_extra"}, 64'(out_valid), 64'(0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        Bi        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:in_ready",  64'(in_ready),  64'(1));
        check("rst:out_valid", 64'(out_valid), 64'(0));
        check("rst:d",         64'(d),         64'(0));
        check("rst:BoV",       {62'b0, Bo, V}, 64'(0));
        rst = 1'b0;

        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 0, "alt");
        run_op(32'h00000100, 32'h00000001, 1'b0, 0, "xchunk");
        run_op(32'h00000000, 32'h00000001, 1'b0, 0, "under");
        run_op(32'h80000000, 32'h00000001, 1'b0, 0, "ovf");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, "allones");
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 5, "backpr");

        // Abort partway through RUN.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hDEADBEEF;
        b        = 32'h01234567;
        Bi       = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort:in_ready",  64'(in_ready),  64'(1));
        check("abort:out_valid", 64'(out_valid), 64'(0));
        check("abort:d",         64'(d),         64'(0));
        run_op(32'h00000005, 32'h00000003, 1'b0, 0, "post_abort");

        for (int k = 0; k < 24; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                   (k % 6 == 5) ? 3 : 0, "rand");
        end
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "pos_ovf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sbc32_seq
`default_nettype wire
